// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: queues note events, scans the voice table one slot
// per clock and issues press/release commands to the synth engine.
module voice_alloc #(
    parameter int NUM_VOICES = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk32,
    input  logic       rst_n,
    input  logic       in_pressed,
    input  logic       in_released,
    input  logic [6:0] in_note,
    input  logic [6:0] in_velocity,
    input  logic [3:0] in_channel,
    output logic       in_ready,
    input  logic       panic,
    output logic       out_pressed,
    output logic       out_released,
    output logic [6:0] out_note,
    output logic [6:0] out_velocity,
    output logic [3:0] out_channel,
    output logic [7:0] out_addr,
    output logic       drop
);

    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 19;

    localparam logic [PW:0]   FULL_CNT = FIFO_DEPTH[PW:0];
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [IW:0]   IDX_END  = NUM_VOICES[IW:0];
    localparam logic [IW:0]   IDX_ONE  = 1;

    typedef enum logic [1:0] {
        V_FREE     = 2'd0,
        V_ACTIVE   = 2'd1,
        V_RELEASED = 2'd2
    } vstate_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_ISSUE = 2'd2
    } fsm_t;

    // ---------------- input event FIFO ----------------
    logic [EW-1:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;

    logic          w_one_qual;
    logic          w_both;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_rd;

    fsm_t          r_state;

    assign in_ready   = (r_count != FULL_CNT);
    assign w_one_qual = in_pressed ^ in_released;
    assign w_both     = in_pressed & in_released;
    assign w_push     = w_one_qual & in_ready & ~panic;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0) && !panic;
    assign w_rd       = r_fifo[r_rptr];

    always_ff @(posedge clk32) begin
        if (w_push) begin
            r_fifo[r_wptr] <= {in_pressed, in_note, in_velocity, in_channel};
        end
    end

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            drop    <= 1'b0;
        end else if (panic) begin
            // Flush silently: an event arriving alongside panic is neither queued nor reported.
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            drop    <= 1'b0;
        end else begin
            drop <= w_both | (w_one_qual & ~in_ready);
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- voice table and allocation FSM ----------------
    vstate_t     r_vstate [NUM_VOICES];
    logic [6:0]  r_vnote  [NUM_VOICES];
    logic [3:0]  r_vchan  [NUM_VOICES];
    logic [7:0]  r_vstamp [NUM_VOICES];

    logic [IW:0] r_idx;
    logic [7:0]  r_counter;

    logic        r_ev_press;
    logic [6:0]  r_ev_note;
    logic [6:0]  r_ev_vel;
    logic [3:0]  r_ev_chan;

    logic        r_hit_f;
    logic [IW-1:0] r_hit_i;
    logic        r_free_f;
    logic [IW-1:0] r_free_i;
    logic        r_rel_f;
    logic [IW-1:0] r_rel_i;
    logic [7:0]  r_rel_age;
    logic        r_act_f;
    logic [IW-1:0] r_act_i;
    logic [7:0]  r_act_age;

    logic [IW-1:0] w_cur;
    logic          w_scan_valid;
    vstate_t       w_cur_state;
    logic          w_match;
    logic [7:0]    w_age;
    logic          w_hit_ok;
    logic [IW-1:0] w_sel;

    assign w_cur        = r_idx[IW-1:0];
    assign w_scan_valid = (r_idx != IDX_END);
    assign w_cur_state  = r_vstate[w_cur];
    assign w_match      = (r_vnote[w_cur] == r_ev_note) && (r_vchan[w_cur] == r_ev_chan);
    assign w_age        = r_counter - r_vstamp[w_cur];

    // A press retriggers any sounding voice on the same key; a release only hits ACTIVE ones.
    assign w_hit_ok = w_match && (r_ev_press ? (w_cur_state != V_FREE)
                                             : (w_cur_state == V_ACTIVE));

    always_comb begin
        w_sel = r_act_i;
        if (r_hit_f) begin
            w_sel = r_hit_i;
        end else if (r_free_f) begin
            w_sel = r_free_i;
        end else if (r_rel_f) begin
            w_sel = r_rel_i;
        end
    end

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_counter    <= '0;
            r_ev_press   <= 1'b0;
            r_ev_note    <= '0;
            r_ev_vel     <= '0;
            r_ev_chan    <= '0;
            r_hit_f      <= 1'b0;
            r_hit_i      <= '0;
            r_free_f     <= 1'b0;
            r_free_i     <= '0;
            r_rel_f      <= 1'b0;
            r_rel_i      <= '0;
            r_rel_age    <= '0;
            r_act_f      <= 1'b0;
            r_act_i      <= '0;
            r_act_age    <= '0;
            out_pressed  <= 1'b0;
            out_released <= 1'b0;
            out_note     <= '0;
            out_velocity <= '0;
            out_channel  <= '0;
            out_addr     <= '0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                r_vstate[v] <= V_FREE;
                r_vnote[v]  <= '0;
                r_vchan[v]  <= '0;
                r_vstamp[v] <= '0;
            end
        end else begin
            out_pressed  <= 1'b0;
            out_released <= 1'b0;
            if (panic) begin
                r_state   <= S_IDLE;
                r_idx     <= '0;
                r_counter <= '0;
                for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                    r_vstate[v] <= V_FREE;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_pop) begin
                            {r_ev_press, r_ev_note, r_ev_vel, r_ev_chan} <= w_rd;
                            r_idx    <= '0;
                            r_hit_f  <= 1'b0;
                            r_free_f <= 1'b0;
                            r_rel_f  <= 1'b0;
                            r_act_f  <= 1'b0;
                            r_state  <= S_SCAN;
                        end
                    end

                    S_SCAN: begin
                        // One extra cycle at idx == NUM_VOICES lets the last candidate settle.
                        if (w_scan_valid) begin
                            r_idx <= r_idx + IDX_ONE;
                            if (!r_hit_f && w_hit_ok) begin
                                r_hit_f <= 1'b1;
                                r_hit_i <= w_cur;
                            end
                            if (!r_free_f && (w_cur_state == V_FREE)) begin
                                r_free_f <= 1'b1;
                                r_free_i <= w_cur;
                            end
                            if ((w_cur_state == V_RELEASED) && (!r_rel_f || (w_age > r_rel_age))) begin
                                r_rel_f   <= 1'b1;
                                r_rel_i   <= w_cur;
                                r_rel_age <= w_age;
                            end
                            if ((w_cur_state == V_ACTIVE) && (!r_act_f || (w_age > r_act_age))) begin
                                r_act_f   <= 1'b1;
                                r_act_i   <= w_cur;
                                r_act_age <= w_age;
                            end
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end

                    S_ISSUE: begin
                        r_state <= S_IDLE;
                        if (r_ev_press) begin
                            r_vstate[w_sel] <= V_ACTIVE;
                            r_vnote[w_sel]  <= r_ev_note;
                            r_vchan[w_sel]  <= r_ev_chan;
                            r_vstamp[w_sel] <= r_counter;
                            r_counter       <= r_counter + 8'd1;
                            out_pressed     <= 1'b1;
                            out_addr        <= 8'(w_sel);
                            out_note        <= r_ev_note;
                            out_velocity    <= r_ev_vel;
                            out_channel     <= r_ev_chan;
                        end else if (r_hit_f) begin
                            r_vstate[r_hit_i] <= V_RELEASED;
                            out_released      <= 1'b1;
                            out_addr          <= 8'(r_hit_i);
                            out_note          <= r_ev_note;
                            out_velocity      <= r_ev_vel;
                            out_channel       <= r_ev_chan;
                        end
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_voice_alloc.sv
// Self-checking bench for voice_alloc: directed vector table, multi-cycle corner
// sequences, and randomized events checked against a behavioural allocation model.
module tb_voice_alloc;

    localparam int NV  = 16;
    localparam int FD  = 4;
    localparam int LAT = NV + 3;

    logic       clk32 = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_pressed = 1'b0;
    logic       in_released = 1'b0;
    logic [6:0] in_note = '0;
    logic [6:0] in_velocity = '0;
    logic [3:0] in_channel = '0;
    logic       panic = 1'b0;
    logic       in_ready;
    logic       out_pressed;
    logic       out_released;
    logic [6:0] out_note;
    logic [6:0] out_velocity;
    logic [3:0] out_channel;
    logic [7:0] out_addr;
    logic       drop;

    voice_alloc #(.NUM_VOICES(NV), .FIFO_DEPTH(FD)) dut (
        .clk32(clk32), .rst_n(rst_n),
        .in_pressed(in_pressed), .in_released(in_released),
        .in_note(in_note), .in_velocity(in_velocity), .in_channel(in_channel),
        .in_ready(in_ready), .panic(panic),
        .out_pressed(out_pressed), .out_released(out_released),
        .out_note(out_note), .out_velocity(out_velocity), .out_channel(out_channel),
        .out_addr(out_addr), .drop(drop)
    );

    always #5 clk32 = ~clk32;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int drops = 0;

    typedef struct {
        logic       p;
        logic [7:0] addr;
        logic [6:0] note;
        logic [6:0] vel;
        logic [3:0] ch;
        int         t;
    } ev_t;
    ev_t obs[$];

    always @(posedge clk32) cyc <= cyc + 1;

    always @(posedge clk32) begin : mon
        ev_t e;
        #1;
        if (out_pressed || out_released) begin
            e.p = out_pressed; e.addr = out_addr; e.note = out_note;
            e.vel = out_velocity; e.ch = out_channel; e.t = cyc;
            obs.push_back(e);
        end
        if (drop) drops++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    task automatic send(input bit p, input bit r, input int n, input int v, input int c, output int t);
        in_pressed = p; in_released = r;
        in_note = 7'(n); in_velocity = 7'(v); in_channel = 4'(c);
        @(posedge clk32);
        #1;
        t = cyc;
        in_pressed = 1'b0; in_released = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    int m_st[NV];      // 0 free, 1 active, 2 released
    int m_note[NV];
    int m_ch[NV];
    int m_stamp[NV];
    int m_cnt;

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_st[i] = 0; m_note[i] = 0; m_ch[i] = 0; m_stamp[i] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic model_evt(input bit p, input int n, input int c, output int kind, output int addr);
        int best;
        int age;
        kind = 0;
        addr = -1;
        if (p) begin
            for (int i = 0; i < NV; i++)
                if (addr < 0 && m_st[i] != 0 && m_note[i] == n && m_ch[i] == c) addr = i;
            for (int i = 0; i < NV; i++)
                if (addr < 0 && m_st[i] == 0) addr = i;
            for (int s = 2; s >= 1; s--) begin
                if (addr < 0) begin
                    best = -1;
                    for (int i = 0; i < NV; i++) begin
                        age = (m_cnt - m_stamp[i]) & 255;
                        if (m_st[i] == s && age > best) begin
                            best = age;
                            addr = i;
                        end
                    end
                end
            end
            m_st[addr] = 1; m_note[addr] = n; m_ch[addr] = c;
            m_stamp[addr] = m_cnt;
            m_cnt = (m_cnt + 1) & 255;
            kind = 1;
        end else begin
            for (int i = 0; i < NV; i++)
                if (addr < 0 && m_st[i] == 1 && m_note[i] == n && m_ch[i] == c) addr = i;
            if (addr >= 0) begin
                m_st[addr] = 2;
                kind = 2;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_pressed = 1'b0; in_released = 1'b0; panic = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        obs.delete();
        drops = 0;
        model_reset();
    endtask

    // Checks the single issued event (or absence of one) after an event accepted at t0.
    task automatic expect_evt(input string name, input int t0, input int kind, input int addr,
                              input int n, input int v, input int c);
        logic [26:0] e;
        e = {(kind == 1), 8'(addr), 7'(n), 7'(v), 4'(c)};
        if (kind == 0) begin
            chk({name, " no-pulse"}, obs.size(), 0);
        end else begin
            chk({name, " count"}, obs.size(), 1);
            if (obs.size() > 0) begin
                chk({name, " fields"}, {obs[0].p, obs[0].addr, obs[0].note, obs[0].vel, obs[0].ch}, e);
                chk({name, " latency"}, obs[0].t - t0, LAT);
            end
        end
        obs.delete();
    endtask

    typedef struct {
        bit p;
        bit r;
        int note;
        int vel;
        int ch;
        int exp_drop;
        int kind;
        int addr;
    } vec_t;
    vec_t tbl[12];

    initial begin : main
        int t0;
        int kind;
        int addr;
        int r;
        int n;
        int v;
        int c;
        logic rdy[5];

        tbl[0]  = '{1, 0, 60, 100, 0, 0, 1, 0};
        tbl[1]  = '{1, 0, 62,  90, 0, 0, 1, 1};
        tbl[2]  = '{1, 0, 64,  80, 0, 0, 1, 2};
        tbl[3]  = '{0, 1, 62,  33, 0, 0, 2, 1};
        tbl[4]  = '{1, 0, 60,  70, 0, 0, 1, 0};
        tbl[5]  = '{0, 1, 61,  10, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 62,  11, 0, 0, 0, 0};
        tbl[7]  = '{1, 0, 62,  55, 0, 0, 1, 1};
        tbl[8]  = '{1, 0, 62,  56, 1, 0, 1, 3};
        tbl[9]  = '{1, 1, 70,  57, 0, 1, 0, 0};
        tbl[10] = '{0, 1, 64,  58, 0, 0, 2, 2};
        tbl[11] = '{1, 0, 66,  59, 0, 0, 1, 4};

        // Reset values
        repeat (2) tick();
        chk("reset in_ready", in_ready, 1);
        chk("reset pulses", {out_pressed, out_released, drop}, 0);
        chk("reset fields", {out_addr, out_note, out_velocity, out_channel}, 0);
        do_reset();

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            send(tbl[i].p, tbl[i].r, tbl[i].note, tbl[i].vel, tbl[i].ch, t0);
            repeat (LAT + 2) tick();
            expect_evt($sformatf("vec%0d", i), t0, tbl[i].kind, tbl[i].addr,
                       tbl[i].note, tbl[i].vel, tbl[i].ch);
            chk($sformatf("vec%0d drop", i), drops, tbl[i].exp_drop);
            drops = 0;
        end

        // Fill all voices, reuse of released voice, then steal of the oldest active
        do_reset();
        for (int k = 0; k < NV; k++) begin
            send(1, 0, 40 + k, 64, 0, t0);
            repeat (LAT + 2) tick();
            expect_evt($sformatf("fill%0d", k), t0, 1, k, 40 + k, 64, 0);
        end
        send(0, 1, 45, 20, 0, t0);  repeat (LAT + 2) tick();
        expect_evt("fill rel45", t0, 2, 5, 45, 20, 0);
        send(1, 0, 70, 99, 0, t0);  repeat (LAT + 2) tick();
        expect_evt("reuse released", t0, 1, 5, 70, 99, 0);
        send(1, 0, 71, 98, 0, t0);  repeat (LAT + 2) tick();
        expect_evt("steal oldest", t0, 1, 0, 71, 98, 0);
        send(1, 0, 72, 97, 0, t0);  repeat (LAT + 2) tick();
        expect_evt("steal next", t0, 1, 1, 72, 97, 0);

        // Back-to-back pushes while scanning: FIFO fills, fifth is dropped
        do_reset();
        send(1, 0, 50, 1, 0, t0);
        repeat (2) tick();
        for (int k = 0; k < 5; k++) begin
            in_pressed = 1'b1; in_note = 7'(51 + k); in_velocity = 7'(2 + k); in_channel = 4'd0;
            @(posedge clk32);
            #1;
            rdy[k] = in_ready;
        end
        in_pressed = 1'b0;
        chk("fifo ready after 3rd", rdy[2], 1);
        chk("fifo ready after 4th", rdy[3], 0);
        repeat (5 * LAT + 10) tick();
        chk("fifo drop count", drops, 1);
        chk("fifo issue count", obs.size(), 5);
        if (obs.size() == 5) begin
            chk("fifo first latency", obs[0].t - t0, LAT);
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("fifo ev%0d", k), {obs[k].p, obs[k].addr, obs[k].note},
                    {1'b1, 8'(k), 7'(50 + k)});
                if (k > 0) chk($sformatf("fifo spacing%0d", k), obs[k].t - obs[k-1].t, LAT);
            end
        end
        obs.delete(); drops = 0;

        // Panic with events queued and an event presented in the same cycle
        do_reset();
        send(1, 0, 50, 1, 0, t0);
        tick();
        for (int k = 0; k < 3; k++) begin
            in_pressed = 1'b1; in_note = 7'(51 + k);
            @(posedge clk32);
            #1;
        end
        in_pressed = 1'b1; in_note = 7'd54; panic = 1'b1;
        @(posedge clk32);
        #1;
        in_pressed = 1'b0; panic = 1'b0;
        chk("panic ready", in_ready, 1);
        repeat (4 * LAT) tick();
        chk("panic no pulses", obs.size(), 0);
        chk("panic no drop", drops, 0);
        send(1, 0, 80, 40, 2, t0); repeat (LAT + 2) tick();
        expect_evt("after panic", t0, 1, 0, 80, 40, 2);

        // Reset asserted mid-scan: asynchronous clear, in-flight event lost
        do_reset();
        send(1, 0, 60, 100, 0, t0); repeat (LAT + 2) tick();
        expect_evt("pre-reset press", t0, 1, 0, 60, 100, 0);
        send(1, 0, 61, 101, 0, t0);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("async reset fields", {out_note, out_velocity, out_addr}, 0);
        chk("async reset ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        repeat (LAT + 5) tick();
        chk("mid-scan reset no pulse", obs.size(), 0);
        send(1, 0, 62, 3, 0, t0); repeat (LAT + 2) tick();
        expect_evt("post-reset press", t0, 1, 0, 62, 3, 0);

        // Randomized events against the reference model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            n = 60 + $urandom_range(0, 5);
            v = $urandom_range(1, 127);
            c = $urandom_range(0, 1);
            if (r == 0) begin
                send(1, 1, n, v, c, t0);
                repeat (LAT + 2) tick();
                chk($sformatf("rnd%0d drop", i), drops, 1);
                chk($sformatf("rnd%0d drop no-pulse", i), obs.size(), 0);
                obs.delete();
            end else begin
                send(r <= 6, r > 6, n, v, c, t0);
                repeat (LAT + 2) tick();
                model_evt(r <= 6, n, c, kind, addr);
                expect_evt($sformatf("rnd%0d", i), t0, kind, addr, n, v, c);
                chk($sformatf("rnd%0d no drop", i), drops, 0);
            end
            drops = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
